uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one on-chip UART transmitter (8-bit data_in/valid/ready side) between NUM_REQ byte
//   producers, e.g. CPU MMIO TX path and a hardware echo/debug path. Round-robin grant, held
//   for a whole packet (until req_last), so bytes from different sources never interleave on
//   serial_out. Sits between the requesters and the transmitter; the transmitter is unchanged.
// PARAMETERS
//   NUM_REQ       2    number of requesters (>=1)
//   DATA_WIDTH    8    byte width passed to the transmitter
//   LOCK_TIMEOUT  4096 cycles the granted source may stall with req_valid=0 mid-packet before the
//                      grant is revoked; 0 disables the timeout
// PORTS
//   clk            in   1                  system clock
//   rst_n          in   1                  reset: asynchronous, active-low
//   req_valid      in   NUM_REQ            per-requester byte valid
//   req_data       in   NUM_REQ*DATA_WIDTH requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last       in   NUM_REQ            byte is final byte of requester's packet
//   req_ready      out  NUM_REQ            per-requester accept
//   tx_data        out  DATA_WIDTH         to transmitter data_in
//   tx_valid       out  1                  to transmitter data_in_valid
//   tx_ready       in   1                  from transmitter data_in_ready
//   grant_valid    out  1                  a requester currently owns the transmitter
//   grant_id       out  max(1,clog2(NUM_REQ)) index of owner (valid only when grant_valid)
//   timeout_pulse  out  1                  1-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset (rst_n=0, any time, incl. mid-packet): state=IDLE, rr_ptr=0, grant_id=0, stall_cnt=0;
//     grant_valid=0, tx_valid=0, tx_data=0, req_ready=0, timeout_pulse=0. A byte already taken
//     by the transmitter finishes on the line; the packet is not resumed.
//   States: IDLE, LOCK.
//   IDLE: no pass-through (tx_valid=0, req_ready=0). If any req_valid: winner = first i with
//     req_valid[i] scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; register grant_id=winner, go LOCK.
//     Arbitration latency: 1 cycle (grant_valid=1 the cycle after the request is seen).
//   LOCK (grant_valid=1): combinational pass-through for g=grant_id only:
//     tx_data=req_data[g], tx_valid=req_valid[g], req_ready[g]=tx_ready, all other req_ready=0.
//     Handshake = req_valid[g] & tx_ready.
//     - handshake & req_last[g]: go IDLE, rr_ptr=(g+1) mod NUM_REQ.
//     - handshake & !req_last[g]: stay LOCK, stall_cnt=0.
//     - req_valid[g]=0 & LOCK_TIMEOUT!=0: stall_cnt++; when stall_cnt reaches LOCK_TIMEOUT-1 and
//       still idle -> next cycle IDLE, rr_ptr=(g+1) mod NUM_REQ, timeout_pulse=1 for that cycle.
//     - req_valid[g]=1 & !tx_ready (transmitter busy): stall_cnt=0, never times out.
//   tx_data is 0 whenever tx_valid=0. tx_valid, once raised, stays with stable tx_data until
//     handshake (requester obligation, passed through unchanged; not checked).
//   Simultaneous: last handshake + other requests same cycle -> IDLE next cycle, new grant the
//     cycle after (2-cycle gap between packets). Requests from non-owners are held off
//     (req_ready=0), never dropped. Revoked requester keeps its turn order: re-arbitrates normally.
//   rr_ptr wraps NUM_REQ-1 -> 0. NUM_REQ=1: grant_id constant 0, arbitration trivial.
//   stall_cnt width clog2(LOCK_TIMEOUT+1); saturates, never wraps.
// TESTING
//   1 Reset: rst_n=0 mid-LOCK -> all outputs 0 same cycle (async), grant_valid=0 after release.
//   2 Single source: req0 sends 8'h31,8'h35,8'h31(last), tx_ready=1 -> tx_data 31,35,31 in order,
//     grant_id=0, grant_valid drops cycle after last.
//   3 Contention: req0 and req1 valid same cycle, rr_ptr=0 -> req0 packet (3 bytes) fully, then
//     req1 packet; next round with both valid -> req1 first (rr_ptr=1).
//   4 No interleave: req1 valid throughout req0 4-byte packet with tx_ready toggling per UART
//     frame -> req_ready[1]=0 until req0 last handshake, serial bytes contiguous per source.
//   5 Timeout: LOCK_TIMEOUT=16, req0 sends 1 non-last byte then drops valid -> timeout_pulse
//     exactly 16 cycles later, grant moves to waiting req1; with valid=1,tx_ready=0 for 100
//     cycles -> no timeout.
//   6 Echo path: CPU loop echoing 'x','y','z','\r' via req0 while req1 injects 8'h3e -> host
//     sees 78,79,7a,0d and 3e as whole packets, none lost or duplicated.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter between NUM_REQ byte producers.
// A silent owner loses the grant after LOCK_TIMEOUT idle cycles (0 disables the timeout).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 4096,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W       = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id,
  output logic                          timeout_pulse
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [CNT_W-1:0] STALL_LIMIT = (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] STALL_MAX   = '1;

  state_t           state, state_next;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_next;
  logic [ID_W-1:0]  grant_id_next;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  next_ptr;
  logic [CNT_W-1:0] stall_cnt, stall_cnt_next;
  logic             timeout_next;
  logic             owner_valid;
  logic             owner_last;
  logic             handshake;
  logic             stall_expired;
  logic             found;
  int               scan_idx;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    winner   = rr_ptr;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[scan_idx]) begin
        winner = ID_W'(scan_idx);
        found  = 1'b1;
      end
    end
  end

  assign next_ptr      = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  assign owner_valid   = req_valid[grant_id];
  assign owner_last    = req_last[grant_id];
  assign handshake     = (state == LOCK) && owner_valid && tx_ready;
  assign stall_expired = (stall_cnt == STALL_LIMIT);

  assign grant_valid = (state == LOCK);
  assign tx_valid    = grant_valid && owner_valid;
  assign tx_data     = tx_valid ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    req_ready = '0;
    if (state == LOCK) begin
      req_ready[grant_id] = tx_ready;
    end
  end

  always_comb begin
    state_next     = state;
    rr_ptr_next    = rr_ptr;
    grant_id_next  = grant_id;
    stall_cnt_next = stall_cnt;
    timeout_next   = 1'b0;
    unique case (state)
      IDLE: begin
        stall_cnt_next = '0;
        if (found) begin
          grant_id_next = winner;
          state_next    = LOCK;
        end
      end
      LOCK: begin
        if (owner_valid) begin
          // A busy transmitter is not the owner's fault, so it never counts toward the timeout.
          stall_cnt_next = '0;
          if (handshake && owner_last) begin
            state_next  = IDLE;
            rr_ptr_next = next_ptr;
          end
        end else if (LOCK_TIMEOUT != 0) begin
          if (stall_expired) begin
            state_next     = IDLE;
            rr_ptr_next    = next_ptr;
            stall_cnt_next = '0;
            timeout_next   = 1'b1;
          end else if (stall_cnt != STALL_MAX) begin
            stall_cnt_next = stall_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      rr_ptr        <= rr_ptr_next;
      grant_id      <= grant_id_next;
      stall_cnt     <= stall_cnt_next;
      timeout_pulse <= timeout_next;
    end
  end

endmodule
